// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter_if
// Brief    : Requester-side and transmitter-side signals of uart_tx_arbiter.
// Revision : 1.0
// ============================================================================
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic                      en_i;
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        done_o;
    logic [NUM_REQ-1:0]        err_o;
    logic                      tx_start_o;
    logic [DATA_W-1:0]         tx_data_o;
    logic                      tx_done_i;
    logic                      tx_err_i;
    logic                      busy_o;
    logic                      timeout_o;

    modport master (
        output en_i, req_i, data_i, tx_done_i, tx_err_i,
        input  gnt_o, done_o, err_o, tx_start_o, tx_data_o, busy_o, timeout_o
    );

    modport slave (
        input  en_i, req_i, data_i, tx_done_i, tx_err_i,
        output gnt_o, done_o, err_o, tx_start_o, tx_data_o, busy_o, timeout_o
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Brief    : Round-robin sharing of one uart_tx among NUM_REQ requesters.
//            Define UART_ARB_TIMEOUT_EN to build the BUSY watchdog.
// Revision : 1.0
// ============================================================================
module uart_tx_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_W         = 8,
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  wire logic         clk_i,
    input  wire logic         rst_i,
    uart_tx_arbiter_if.slave  bus
);
    localparam int c_PTR_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RECOVER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [c_PTR_W-1:0]  ptr_q, ptr_d;
    logic [c_PTR_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0]   tx_data_q, tx_data_d;
    logic                tx_start_q, tx_start_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [NUM_REQ-1:0]  done_q, done_d;
    logic [NUM_REQ-1:0]  err_q, err_d;
    logic                timeout_q, timeout_d;
    logic                done_hist_q, done_hist_d;

    logic                w_tx_rise;
    logic                w_expire;
    logic                w_win_found;
    logic [c_PTR_W-1:0]  w_win_idx;
    int                  w_j;

    assign w_tx_rise = bus.tx_done_i & ~done_hist_q;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    logic [c_CNT_W-1:0] cnt_q, cnt_d;

    // Held at zero outside BUSY, so each frame starts counting from 0.
    always_comb begin
        cnt_d = '0;
        if (state_q == S_BUSY) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign w_expire = (state_q == S_BUSY) && (cnt_q == c_CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign w_expire = 1'b0;
`endif

    // First set request at or above ptr, wrapping to 0.
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_j         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_j = int'(ptr_q) + i;
            if (w_j >= NUM_REQ) begin
                w_j = w_j - NUM_REQ;
            end
            if (!w_win_found && bus.req_i[w_j]) begin
                w_win_found = 1'b1;
                w_win_idx   = c_PTR_W'(w_j);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        idx_d       = idx_q;
        tx_data_d   = tx_data_q;
        tx_start_d  = tx_start_q;
        gnt_d       = '0;
        done_d      = '0;
        err_d       = '0;
        timeout_d   = 1'b0;
        done_hist_d = bus.tx_done_i;

        case (state_q)
            S_IDLE: begin
                if (bus.en_i && w_win_found && !bus.tx_done_i) begin
                    gnt_d[w_win_idx] = 1'b1;
                    tx_data_d        = bus.data_i[int'(w_win_idx)*DATA_W +: DATA_W];
                    tx_start_d       = 1'b1;
                    idx_d            = w_win_idx;
                    state_d          = S_BUSY;
                end
            end
            S_BUSY: begin
                // A genuine completion takes priority over a coincident expiry.
                if (w_tx_rise || w_expire) begin
                    tx_start_d     = 1'b0;
                    done_d[idx_q]  = 1'b1;
                    err_d[idx_q]   = w_tx_rise ? bus.tx_err_i : 1'b1;
                    timeout_d      = ~w_tx_rise;
                    ptr_d          = (int'(idx_q) == NUM_REQ - 1) ? '0 : idx_q + 1'b1;
                    state_d        = S_RECOVER;
                end
            end
            S_RECOVER: begin
                if (!bus.tx_done_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d    = S_IDLE;
                tx_start_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            idx_q       <= '0;
            tx_data_q   <= '0;
            tx_start_q  <= 1'b0;
            gnt_q       <= '0;
            done_q      <= '0;
            err_q       <= '0;
            timeout_q   <= 1'b0;
            done_hist_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            idx_q       <= idx_d;
            tx_data_q   <= tx_data_d;
            tx_start_q  <= tx_start_d;
            gnt_q       <= gnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            done_hist_q <= done_hist_d;
        end
    end

    assign bus.gnt_o      = gnt_q;
    assign bus.done_o     = done_q;
    assign bus.err_o      = err_q;
    assign bus.tx_start_o = tx_start_q;
    assign bus.tx_data_o  = tx_data_q;
    assign bus.busy_o     = (state_q != S_IDLE);
    assign bus.timeout_o  = timeout_q;
endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_arbiter
// Brief    : Directed scoreboard bench for uart_tx_arbiter; the watchdog
//            section follows UART_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module tb_uart_tx_arbiter;
    localparam int NUM_REQ        = 4;
    localparam int DATA_W         = 8;
    localparam int TIMEOUT_CYCLES = 16;

    typedef struct packed {
        logic [3:0] idx;
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t cur;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

    uart_tx_arbiter #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk_i (clk),
        .rst_i (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t mk(input int idx, input int data, input bit err);
        exp_t e;
        e.idx  = 4'(idx);
        e.data = 8'(data);
        e.err  = err;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Waits (bounded) for a grant and compares it with the next scoreboard entry.
    task automatic wait_gnt(input string tag);
        int n;
        n = 0;
        @(negedge clk);
        while (bus.gnt_o == '0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 32'(sb.size()), 32'(1));
            cur = mk(0, 0, 1'b0);
        end else begin
            cur = sb.pop_front();
        end
        check({tag, "_gnt"},      32'(bus.gnt_o), 32'(1) << cur.idx);
        check({tag, "_tx_data"},  32'(bus.tx_data_o), 32'(cur.data));
        check({tag, "_tx_start"}, 32'(bus.tx_start_o), 32'(1));
        check({tag, "_busy"},     32'(bus.busy_o), 32'(1));
    endtask

    // Pulses tx_done with the expected error flag and checks completion.
    task automatic finish_frame(input string tag);
        bus.tx_done_i = 1'b1;
        bus.tx_err_i  = cur.err;
        @(negedge clk);
        check({tag, "_done"},     32'(bus.done_o), 32'(1) << cur.idx);
        check({tag, "_err"},      32'(bus.err_o), cur.err ? (32'(1) << cur.idx) : 32'(0));
        check({tag, "_tx_start0"}, 32'(bus.tx_start_o), 32'(0));
        check({tag, "_gnt_excl"}, 32'(bus.gnt_o), 32'(0));
        check({tag, "_timeout0"}, 32'(bus.timeout_o), 32'(0));
        bus.tx_done_i = 1'b0;
        bus.tx_err_i  = 1'b0;
        @(negedge clk);
        check({tag, "_busy0"},    32'(bus.busy_o), 32'(0));
        check({tag, "_done0"},    32'(bus.done_o), 32'(0));
    endtask

    initial begin
        logic [NUM_REQ-1:0] seen;
        logic               seen_to;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.en_i      = 1'b1;
        bus.req_i     = '0;
        bus.data_i    = '0;
        bus.tx_done_i = 1'b0;
        bus.tx_err_i  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_gnt",      32'(bus.gnt_o), 32'(0));
        check("rst_done",     32'(bus.done_o), 32'(0));
        check("rst_err",      32'(bus.err_o), 32'(0));
        check("rst_tx_start", 32'(bus.tx_start_o), 32'(0));
        check("rst_tx_data",  32'(bus.tx_data_o), 32'(0));
        check("rst_busy",     32'(bus.busy_o), 32'(0));
        check("rst_timeout",  32'(bus.timeout_o), 32'(0));
        rst_n = 1'b1;
        @(negedge clk);

        // Single request from requester 2.
        bus.data_i = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus.req_i  = 4'b0100;
        sb.push_back(mk(2, 8'hA5, 1'b0));
        wait_gnt("single");
        bus.req_i = '0;
        bus.data_i = {8'h00, 8'h5A, 8'h00, 8'h00};
        repeat (3) @(negedge clk);
        check("single_hold_data",  32'(bus.tx_data_o), 32'hA5);
        check("single_hold_start", 32'(bus.tx_start_o), 32'(1));
        check("single_no_regnt",   32'(bus.gnt_o), 32'(0));
        finish_frame("single");

        // Round-robin from a freshly reset pointer.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        bus.data_i = {8'h13, 8'h12, 8'h11, 8'h10};
        bus.req_i  = 4'b1111;
        for (int f = 0; f < 8; f++) sb.push_back(mk(f % 4, 8'h10 + (f % 4), 1'b0));
        for (int f = 0; f < 8; f++) begin
            wait_gnt("rr");
            if (f == 7) bus.req_i = '0;
            finish_frame("rr");
        end

        // Error propagation on requester 1.
        bus.data_i = {8'h00, 8'h00, 8'h3C, 8'h00};
        bus.req_i  = 4'b0010;
        sb.push_back(mk(1, 8'h3C, 1'b1));
        wait_gnt("err");
        bus.req_i = '0;
        finish_frame("err");

        // A stale done level in IDLE blocks the grant.
        bus.tx_done_i = 1'b1;
        bus.data_i    = {8'h00, 8'h00, 8'h00, 8'h77};
        bus.req_i     = 4'b0001;
        seen = '0;
        repeat (5) begin
            @(negedge clk);
            seen |= bus.gnt_o;
        end
        check("stale_no_gnt", 32'(seen), 32'(0));
        check("stale_busy",   32'(bus.busy_o), 32'(0));
        sb.push_back(mk(0, 8'h77, 1'b0));
        bus.tx_done_i = 1'b0;
        wait_gnt("stale");
        bus.req_i = '0;
        bus.en_i  = 1'b0;
        repeat (2) @(negedge clk);
        check("en_drop_hold", 32'(bus.tx_start_o), 32'(1));
        finish_frame("en_drop");

        // en_i low blocks new grants.
        bus.data_i = {8'h00, 8'h99, 8'h00, 8'h00};
        bus.req_i  = 4'b0100;
        seen = '0;
        repeat (5) begin
            @(negedge clk);
            seen |= bus.gnt_o;
        end
        check("en_low_no_gnt", 32'(seen), 32'(0));
        sb.push_back(mk(2, 8'h99, 1'b0));
        bus.en_i = 1'b1;
        wait_gnt("en_high");
        bus.req_i = '0;
        finish_frame("en_high");

        // Reset in the middle of a frame.
        bus.data_i = {8'hD4, 8'hC3, 8'hB2, 8'hA1};
        bus.req_i  = 4'b0001;
        sb.push_back(mk(0, 8'hA1, 1'b0));
        wait_gnt("midrst");
        bus.req_i = '0;
        rst_n     = 1'b0;
        @(negedge clk);
        check("midrst_tx_start", 32'(bus.tx_start_o), 32'(0));
        check("midrst_done",     32'(bus.done_o), 32'(0));
        check("midrst_busy",     32'(bus.busy_o), 32'(0));
        rst_n     = 1'b1;
        bus.req_i = 4'b1010;
        sb.push_back(mk(1, 8'hB2, 1'b0));
        wait_gnt("after_rst");
        bus.req_i = '0;
        finish_frame("after_rst");

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog abort TIMEOUT_CYCLES cycles after the grant.
        bus.req_i = 4'b0001;
        sb.push_back(mk(0, 8'hA1, 1'b1));
        wait_gnt("to");
        bus.req_i = '0;
        seen_to = 1'b0;
        repeat (TIMEOUT_CYCLES - 1) begin
            @(negedge clk);
            seen_to |= bus.timeout_o | (|bus.done_o);
        end
        check("to_early", 32'(seen_to), 32'(0));
        @(negedge clk);
        check("to_timeout",  32'(bus.timeout_o), 32'(1));
        check("to_done",     32'(bus.done_o), 32'(1) << cur.idx);
        check("to_err",      32'(bus.err_o), 32'(1) << cur.idx);
        check("to_tx_start", 32'(bus.tx_start_o), 32'(0));
        @(negedge clk);
        check("to_busy0",    32'(bus.busy_o), 32'(0));

        // Completion in the expiry cycle wins.
        bus.req_i = 4'b0001;
        sb.push_back(mk(0, 8'hA1, 1'b0));
        wait_gnt("to_race");
        bus.req_i = '0;
        repeat (TIMEOUT_CYCLES - 1) @(negedge clk);
        finish_frame("to_race");
`else
        // Without the watchdog a frame waits indefinitely.
        bus.req_i = 4'b0001;
        sb.push_back(mk(0, 8'hA1, 1'b0));
        wait_gnt("no_to");
        bus.req_i = '0;
        seen_to = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen_to |= bus.timeout_o | (|bus.done_o) | ~bus.tx_start_o;
        end
        check("no_to_wait", 32'(seen_to), 32'(0));
        finish_frame("no_to");
`endif

        check("sb_drained", 32'(sb.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
